// File: rtl/vga_flag_latch_bank.sv
// Bank of WIDTH clocked set/clear flags for VGA control events. Each flag has optional
// input synchronisers, optional edge triggering, rise/fall pulses and a saturating rise counter.
module vga_flag_latch_bank #(
  parameter int WIDTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int SET_DOMINANT = 0,
  parameter int EDGE_MODE    = 0,
  parameter int CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       set,
  input  logic [WIDTH-1:0]       clr,
  input  logic                   cnt_clear,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_rise,
  output logic [WIDTH-1:0]       q_fall,
  output logic                   any_q,
  output logic [WIDTH*CNT_W-1:0] rise_cnt
);

  localparam logic             SET_WINS = (SET_DOMINANT != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] s, c;    // synchronised requests
  logic [WIDTH-1:0] es, ec;  // effective requests after optional edge detection
  logic [WIDTH-1:0] n;       // next flag state
  logic [WIDTH-1:0] rise;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = set;
      assign c = clr;
    end else begin : g_sync
      logic [WIDTH-1:0] s_chain [SYNC_STAGES];
      logic [WIDTH-1:0] c_chain [SYNC_STAGES];

      // NOTE: every flop here uses <= so all stages shift on the same edge; blocking
      // assignments would collapse the chain into a single stage.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            s_chain[k] <= '0;
            c_chain[k] <= '0;
          end
        end else begin
          s_chain[0] <= set;
          c_chain[0] <= clr;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            s_chain[k] <= s_chain[k-1];
            c_chain[k] <= c_chain[k-1];
          end
        end
      end

      assign s = s_chain[SYNC_STAGES-1];
      assign c = c_chain[SYNC_STAGES-1];
    end

    if (EDGE_MODE != 0) begin : g_edge
      logic [WIDTH-1:0] s_d, c_d;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s_d <= '0;
          c_d <= '0;
        end else begin
          s_d <= s;
          c_d <= c;
        end
      end

      assign es = s & ~s_d;
      assign ec = c & ~c_d;
    end else begin : g_level
      assign es = s;
      assign ec = c;
    end
  endgenerate

  // Conflicting requests resolve to the configured winner; idle channels hold.
  assign n    = (es & ~ec) | (~es & ~ec & q) | (es & ec & {WIDTH{SET_WINS}});
  assign rise = n & ~q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q      <= '0;
      q_rise <= '0;
      q_fall <= '0;
      any_q  <= 1'b0;
    end else begin
      q      <= n;
      q_rise <= rise;
      q_fall <= ~n & q;
      any_q  <= |n;
    end
  end

  logic [CNT_W-1:0] cnt [WIDTH];

  // NOTE: the counter array is ordinary flops, not RAM, so it is cleared by reset
  // like any other state; a RAM-mapped array could not be reset this way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt_clear)
          cnt[i] <= rise[i] ? CNT_ONE : '0;
        else if (rise[i] && cnt[i] != CNT_MAX)
          cnt[i] <= cnt[i] + CNT_ONE;
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cnt_out
    assign rise_cnt[gi*CNT_W +: CNT_W] = cnt[gi];
  end

endmodule

// File: tb/tb_vga_flag_latch_bank.sv
// Self-checking bench for vga_flag_latch_bank: vector table, directed corner sequences on
// three configurations, and randomized traffic against a behavioural model.
module tb_vga_flag_latch_bank;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults (level mode, clear wins, 2 sync stages, 8-bit counters)
  logic [3:0]  a_set = '0, a_clr = '0;
  logic        a_cnt_clear = 1'b0;
  logic [3:0]  a_q, a_rise, a_fall;
  logic        a_any;
  logic [31:0] a_cnt;

  vga_flag_latch_bank u_a (
    .clk(clk), .reset(reset), .set(a_set), .clr(a_clr), .cnt_clear(a_cnt_clear),
    .q(a_q), .q_rise(a_rise), .q_fall(a_fall), .any_q(a_any), .rise_cnt(a_cnt)
  );

  // Instance B: edge mode, set wins, 3-bit counters
  logic [3:0]  b_set = '0, b_clr = '0;
  logic        b_cnt_clear = 1'b0;
  logic [3:0]  b_q, b_rise, b_fall;
  logic        b_any;
  logic [11:0] b_cnt;

  vga_flag_latch_bank #(
    .WIDTH(4), .SYNC_STAGES(2), .SET_DOMINANT(1), .EDGE_MODE(1), .CNT_W(3)
  ) u_b (
    .clk(clk), .reset(reset), .set(b_set), .clr(b_clr), .cnt_clear(b_cnt_clear),
    .q(b_q), .q_rise(b_rise), .q_fall(b_fall), .any_q(b_any), .rise_cnt(b_cnt)
  );

  // Instance C: no synchroniser, 1-bit counters
  logic [1:0]  c_set = '0, c_clr = '0;
  logic        c_cnt_clear = 1'b0;
  logic [1:0]  c_q, c_rise, c_fall;
  logic        c_any;
  logic [1:0]  c_cnt;

  vga_flag_latch_bank #(
    .WIDTH(2), .SYNC_STAGES(0), .SET_DOMINANT(0), .EDGE_MODE(0), .CNT_W(1)
  ) u_c (
    .clk(clk), .reset(reset), .set(c_set), .clr(c_clr), .cnt_clear(c_cnt_clear),
    .q(c_q), .q_rise(c_rise), .q_fall(c_fall), .any_q(c_any), .rise_cnt(c_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  set;
    logic [3:0]  clr;
    logic [3:0]  q;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic        any;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [8];

  // Behavioural model of instance A: requests travel through a two-entry delay queue,
  // then the flag rules are applied channel by channel with plain integer counting.
  logic [3:0] pipe_s [$];
  logic [3:0] pipe_c [$];
  logic [3:0] m_q, m_rise, m_fall;
  int         m_cnt [4];

  task automatic model_reset();
    pipe_s = {4'b0, 4'b0};
    pipe_c = {4'b0, 4'b0};
    m_q = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step(input logic [3:0] set_in, input logic [3:0] clr_in, input logic clear_in);
    logic [3:0] s_now, c_now;
    logic       nxt, rose;
    s_now = pipe_s.pop_front();
    c_now = pipe_c.pop_front();
    pipe_s.push_back(set_in);
    pipe_c.push_back(clr_in);
    for (int i = 0; i < 4; i++) begin
      if (s_now[i] && c_now[i]) nxt = 1'b0;
      else if (s_now[i])        nxt = 1'b1;
      else if (c_now[i])        nxt = 1'b0;
      else                      nxt = m_q[i];
      rose      = nxt && !m_q[i];
      m_rise[i] = rose;
      m_fall[i] = !nxt && m_q[i];
      m_q[i]    = nxt;
      if (clear_in)  m_cnt[i] = rose ? 1 : 0;
      else if (rose) m_cnt[i] = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
    end
  endtask

  initial begin
    logic [3:0]  prev_q;
    logic [31:0] exp_cnt;
    logic [3:0]  r_set, r_clr;
    logic        r_clear;

    tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b1, 32'h0000_0001};
    tbl[1] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 32'h0000_0001};
    tbl[2] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0000_0001};
    tbl[3] = '{4'b1011, 4'b0000, 4'b1011, 4'b1011, 4'b0000, 1'b1, 32'h0100_0102};
    tbl[4] = '{4'b0001, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 1'b1, 32'h0100_0102};
    tbl[5] = '{4'b0100, 4'b1000, 4'b0111, 4'b0100, 4'b1000, 1'b1, 32'h0101_0102};
    tbl[6] = '{4'b0000, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 1'b1, 32'h0101_0102};
    tbl[7] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0111, 1'b0, 32'h0101_0102};

    // Reset state
    tick(2);
    check("reset_state_a", {a_q, a_rise, a_fall, a_any, a_cnt}, 64'h0);
    reset = 1'b0;
    tick(1);

    // Table: one-cycle request, q must still be old after 2 edges and new after 3
    prev_q = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      a_set = tbl[i].set;
      a_clr = tbl[i].clr;
      tick(1);
      a_set = '0;
      a_clr = '0;
      tick(1);
      check($sformatf("tbl%0d_latency_q", i), a_q, prev_q);
      tick(1);
      check($sformatf("tbl%0d_q", i), a_q, tbl[i].q);
      check($sformatf("tbl%0d_rise", i), a_rise, tbl[i].rise);
      check($sformatf("tbl%0d_fall", i), a_fall, tbl[i].fall);
      check($sformatf("tbl%0d_any", i), a_any, tbl[i].any);
      check($sformatf("tbl%0d_cnt", i), a_cnt, tbl[i].cnt);
      prev_q = tbl[i].q;
    end

    // B: set and clr held together, set wins
    b_set[1] = 1'b1;
    b_clr[1] = 1'b1;
    tick(3);
    check("b_simul_q1", b_q[1], 1'b1);
    tick(3);
    check("b_simul_hold_q1", b_q[1], 1'b1);
    check("b_simul_cnt1", b_cnt[5:3], 3'd1);
    b_set[1] = 1'b0;
    b_clr[1] = 1'b0;
    tick(3);

    // B: edge mode, set held 10 cycles with a clear pulse in cycle 5
    b_set[2] = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      b_clr[2] = (cyc == 5);
      tick(1);
      if (cyc == 3)  check("b_edge_rise", {b_q[2], b_rise[2]}, 2'b11);
      if (cyc == 7)  check("b_edge_fall", {b_q[2], b_fall[2]}, 2'b01);
      if (cyc == 10) check("b_edge_q_after_clr", b_q[2], 1'b0);
    end
    tick(3);
    check("b_edge_no_rerise", {b_q[2], b_cnt[8:6]}, {1'b0, 3'd1});
    b_set[2] = 1'b0;
    tick(1);
    b_set[2] = 1'b1;
    tick(3);
    check("b_edge_second_rise", {b_q[2], b_cnt[8:6]}, {1'b1, 3'd2});
    b_set[2] = 1'b0;
    b_clr[2] = 1'b1;
    tick(1);
    b_clr[2] = 1'b0;
    tick(3);

    // B: saturation of the 3-bit counter on channel 3
    for (int k = 1; k <= 9; k++) begin
      b_set[3] = 1'b1;
      tick(1);
      b_set[3] = 1'b0;
      tick(3);
      check($sformatf("b_sat_cnt3_%0d", k), b_cnt[11:9], (k > 7) ? 3'd7 : 3'(k));
      b_clr[3] = 1'b1;
      tick(1);
      b_clr[3] = 1'b0;
      tick(3);
    end

    // B: cnt_clear on the same edge as a rise on channel 0
    b_set[0] = 1'b1;
    tick(1);
    b_set[0] = 1'b0;
    tick(1);
    b_cnt_clear = 1'b1;
    tick(1);
    b_cnt_clear = 1'b0;
    check("b_cntclr_rise0", b_rise[0], 1'b1);
    check("b_cntclr_cnt", b_cnt, 12'b000_000_000_001);

    // C: no synchroniser, request visible after its sampling edge; 1-bit counter saturates
    c_set = 2'b01;
    tick(1);
    check("c_direct_set", {c_q, c_rise, c_cnt}, {2'b01, 2'b01, 2'b01});
    c_set = 2'b00;
    c_clr = 2'b01;
    tick(1);
    check("c_direct_clr", {c_q, c_fall}, {2'b00, 2'b01});
    c_clr = 2'b00;
    c_set = 2'b01;
    tick(1);
    c_set = 2'b00;
    check("c_cnt_saturate", {c_q, c_cnt}, {2'b01, 2'b01});

    // A: asynchronous reset with state held and a set in flight
    a_set = 4'b1011;
    tick(1);
    a_set = 4'b0000;
    tick(3);
    check("a_pre_reset_q", a_q, 4'b1011);
    a_set = 4'b0100;
    tick(1);
    a_set = 4'b0000;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("a_async_reset", {a_q, a_rise, a_fall, a_any, a_cnt}, 64'h0);
    check("b_async_reset", {b_q, b_any, b_cnt}, 64'h0);
    tick(1);
    reset = 1'b0;
    tick(6);
    check("a_no_replay", {a_q, a_any, a_cnt}, 64'h0);

    // A: randomized traffic against the behavioural model
    model_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      r_set   = 4'($urandom & $urandom);
      r_clr   = 4'($urandom & $urandom);
      r_clear = ($urandom_range(0, 15) == 0);
      a_set = r_set;
      a_clr = r_clr;
      a_cnt_clear = r_clear;
      @(posedge clk);
      model_step(r_set, r_clr, r_clear);
      @(negedge clk);
      for (int i = 0; i < 4; i++) exp_cnt[i*8 +: 8] = 8'(m_cnt[i]);
      check($sformatf("rand_cyc%0d", cyc), {a_q, a_rise, a_fall, a_any, a_cnt},
            {m_q, m_rise, m_fall, |m_q, exp_cnt});
    end
    a_set = '0;
    a_clr = '0;
    a_cnt_clear = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
